// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad code entry front end.
//   CODE_W : width of an assembled code (4 bits per hex digit).
//   key_e  : encoding of the key_type input.
//   state_e: entry phase (login/old code, or new code).
package keypad_pkg;

  localparam int CODE_W = 16;

  typedef enum logic [1:0] {
    KEY_DIGIT = 2'b00,
    KEY_ENT   = 2'b01,
    KEY_CHG   = 2'b10,
    KEY_CLR   = 2'b11
  } key_e;

  typedef enum logic {
    S_OLD = 1'b0,
    S_NEW = 1'b1
  } state_e;

endpackage

// File: rtl/keypad_idle_timer.sv
// keypad_idle_timer: idle counter that flags a stale partial entry.
//   clk, reset : clock, asynchronous active-low reset
//   reload     : an accepted key; restarts the count from 0
//   run        : an entry is in progress, so idle time is counted
//   expire     : TIMEOUT_CYCLES-1 idle cycles have elapsed; the owner
//                discards the entry on the next edge
module keypad_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  input  logic run,
  output logic expire
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // A key in the expiry cycle wins, so reload masks expire.
  assign expire = run && !reload && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (reload || expire || !run) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/keypad_code_entry.sv
// keypad_code_entry: assembles hex keypad strokes into 16-bit codes and
// issues one-cycle login (enter) and change-password (chg_pass) commands.
//   clk, reset  : clock, asynchronous active-low reset
//   key_valid   : one-cycle key strobe
//   key_type    : 00 DIGIT, 01 ENT, 10 CHG, 11 CLR
//   key_digit   : hex digit value (DIGIT only)
//   passin      : login / old code, held between commands
//   newpass     : new code, held between commands
//   enter       : one-cycle login command
//   chg_pass    : one-cycle change-password command
//   digit_cnt   : digits in the current buffer (0..DIGITS)
//   phase_new   : high while collecting the new code
//   timeout_evt : one-cycle pulse when an idle entry is discarded
// Build option: define KEYPAD_TIMEOUT_EN to include the idle timeout;
// without it timeout_evt stays 0 and partial entries persist.
module keypad_code_entry
  import keypad_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [1:0]        key_type,
  input  logic [3:0]        key_digit,
  output logic [CODE_W-1:0] passin,
  output logic [CODE_W-1:0] newpass,
  output logic              enter,
  output logic              chg_pass,
  output logic [2:0]        digit_cnt,
  output logic              phase_new,
  output logic              timeout_evt
);

  if (4 * DIGITS != CODE_W || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("keypad_code_entry: DIGITS must give a 16-bit code and TIMEOUT_CYCLES must be nonzero");
  end

  localparam logic [2:0] FULL = 3'(DIGITS);

  state_e              state, state_n;
  logic [CODE_W-1:0]   code_buf, code_buf_n;
  logic [CODE_W-1:0]   old_hold, old_hold_n;
  logic [CODE_W-1:0]   passin_n, newpass_n;
  logic [2:0]          cnt_n;
  logic                enter_n, chg_n, tevt_n;
  logic                expire;
  logic                full;

  assign full = (digit_cnt == FULL);

`ifdef KEYPAD_TIMEOUT_EN
  keypad_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .reset (reset),
    .reload(key_valid),
    .run   ((digit_cnt != '0) || (state == S_NEW)),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_OLD;
      code_buf    <= '0;
      old_hold    <= '0;
      passin      <= '0;
      newpass     <= '0;
      enter       <= 1'b0;
      chg_pass    <= 1'b0;
      digit_cnt   <= '0;
      phase_new   <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_n;
      code_buf    <= code_buf_n;
      old_hold    <= old_hold_n;
      passin      <= passin_n;
      newpass     <= newpass_n;
      enter       <= enter_n;
      chg_pass    <= chg_n;
      digit_cnt   <= cnt_n;
      // Registered copy of the next state so the output has no decode logic.
      phase_new   <= (state_n == S_NEW);
      timeout_evt <= tevt_n;
    end
  end

  always_comb begin
    state_n    = state;
    code_buf_n = code_buf;
    old_hold_n = old_hold;
    passin_n   = passin;
    newpass_n  = newpass;
    cnt_n      = digit_cnt;
    enter_n    = 1'b0;
    chg_n      = 1'b0;
    tevt_n     = 1'b0;

    if (key_valid) begin
      unique case (key_e'(key_type))
        KEY_DIGIT: begin
          if (!full) begin
            code_buf_n = {code_buf[CODE_W-5:0], key_digit};
            cnt_n      = digit_cnt + 3'd1;
          end
        end
        KEY_ENT: begin
          if (state == S_OLD) begin
            if (full) begin
              passin_n = code_buf;
              enter_n  = 1'b1;
            end
          end else if (full) begin
            passin_n  = old_hold;
            newpass_n = code_buf;
            chg_n     = 1'b1;
          end
          // Every ENT ends the current entry, issued or aborted.
          state_n    = S_OLD;
          old_hold_n = '0;
          code_buf_n = '0;
          cnt_n      = '0;
        end
        KEY_CHG: begin
          if (state == S_OLD && full) begin
            old_hold_n = code_buf;
            state_n    = S_NEW;
            code_buf_n = '0;
            cnt_n      = '0;
          end
        end
        KEY_CLR: begin
          state_n    = S_OLD;
          old_hold_n = '0;
          code_buf_n = '0;
          cnt_n      = '0;
        end
        default: ;
      endcase
    end else if (expire) begin
      state_n    = S_OLD;
      old_hold_n = '0;
      code_buf_n = '0;
      cnt_n      = '0;
      tevt_n     = 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_code_entry.sv
// tb_keypad_code_entry: directed bench for keypad_code_entry.
// Build option: define KEYPAD_TIMEOUT_EN to exercise the idle timeout
// with TIMEOUT_CYCLES=8.
module tb_keypad_code_entry;
  import keypad_pkg::*;

  logic        clk;
  logic        reset;
  logic        key_valid;
  logic [1:0]  key_type;
  logic [3:0]  key_digit;
  logic [15:0] passin;
  logic [15:0] newpass;
  logic        enter;
  logic        chg_pass;
  logic [2:0]  digit_cnt;
  logic        phase_new;
  logic        timeout_evt;

  int unsigned tests_run;
  int unsigned tests_failed;

`ifdef KEYPAD_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 1000000;
`endif

  keypad_code_entry #(
    .DIGITS        (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_type   (key_type),
    .key_digit  (key_digit),
    .passin     (passin),
    .newpass    (newpass),
    .enter      (enter),
    .chg_pass   (chg_pass),
    .digit_cnt  (digit_cnt),
    .phase_new  (phase_new),
    .timeout_evt(timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one key for a single cycle; returns on the following negedge,
  // where the registered result of that key is visible.
  task automatic press(input logic [1:0] t, input logic [3:0] d);
    @(negedge clk);
    key_valid = 1'b1;
    key_type  = t;
    key_digit = d;
    @(negedge clk);
    key_valid = 1'b0;
    key_type  = 2'b00;
    key_digit = 4'h0;
  endtask

  task automatic digit(input logic [3:0] d);
    press(KEY_DIGIT, d);
  endtask

  task automatic ent();
    press(KEY_ENT, 4'h0);
  endtask

  task automatic chg();
    press(KEY_CHG, 4'h0);
  endtask

  task automatic code4(input logic [15:0] c);
    digit(c[15:12]); digit(c[11:8]); digit(c[7:4]); digit(c[3:0]);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    key_valid    = 1'b0;
    key_type     = 2'b00;
    key_digit    = 4'h0;
    reset        = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_passin",  32'(passin), 32'h0);
    check("rst_newpass", 32'(newpass), 32'h0);
    check("rst_enter",   32'(enter), 32'h0);
    check("rst_chg",     32'(chg_pass), 32'h0);
    check("rst_cnt",     32'(digit_cnt), 32'h0);
    check("rst_phase",   32'(phase_new), 32'h0);
    check("rst_tevt",    32'(timeout_evt), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Login 1234
    code4(16'h1234);
    check("login_cnt4",   32'(digit_cnt), 32'd4);
    check("login_enter0", 32'(enter), 32'h0);
    ent();
    check("login_enter",  32'(enter), 32'h1);
    check("login_chg",    32'(chg_pass), 32'h0);
    check("login_passin", 32'(passin), 32'h1234);
    check("login_cnt0",   32'(digit_cnt), 32'd0);
    @(negedge clk);
    check("login_enter_1cyc", 32'(enter), 32'h0);
    check("login_passin_hold", 32'(passin), 32'h1234);

    // Change password 1234 -> 5678
    code4(16'h1234);
    chg();
    check("chg_phase1", 32'(phase_new), 32'h1);
    check("chg_cnt0",   32'(digit_cnt), 32'd0);
    check("chg_noenter", 32'(enter), 32'h0);
    code4(16'h5678);
    ent();
    check("chg_pulse",   32'(chg_pass), 32'h1);
    check("chg_enter0",  32'(enter), 32'h0);
    check("chg_passin",  32'(passin), 32'h1234);
    check("chg_newpass", 32'(newpass), 32'h5678);
    check("chg_phase0",  32'(phase_new), 32'h0);
    @(negedge clk);
    check("chg_pulse_1cyc", 32'(chg_pass), 32'h0);
    check("chg_newpass_hold", 32'(newpass), 32'h5678);

    // Short entry is discarded
    digit(4'h1); digit(4'h2);
    ent();
    check("short_enter", 32'(enter), 32'h0);
    check("short_cnt",   32'(digit_cnt), 32'd0);
    check("short_passin", 32'(passin), 32'h1234);

    // Fifth digit dropped
    code4(16'h1234);
    digit(4'h5);
    check("drop_cnt", 32'(digit_cnt), 32'd4);
    ent();
    check("drop_enter",  32'(enter), 32'h1);
    check("drop_passin", 32'(passin), 32'h1234);

    // CHG with partial buffer is ignored, buffer kept
    digit(4'hA); digit(4'hB);
    chg();
    check("pchg_phase", 32'(phase_new), 32'h0);
    check("pchg_cnt",   32'(digit_cnt), 32'd2);
    digit(4'hC); digit(4'hD);
    check("pchg_cnt4",  32'(digit_cnt), 32'd4);
    ent();
    check("pchg_enter",  32'(enter), 32'h1);
    check("pchg_passin", 32'(passin), 32'habcd);

    // CLR in S_NEW
    code4(16'h1234);
    chg();
    digit(4'h9);
    check("clr_pre_cnt",   32'(digit_cnt), 32'd1);
    check("clr_pre_phase", 32'(phase_new), 32'h1);
    press(KEY_CLR, 4'h0);
    check("clr_phase", 32'(phase_new), 32'h0);
    check("clr_cnt",   32'(digit_cnt), 32'd0);
    check("clr_enter", 32'(enter), 32'h0);
    check("clr_chg",   32'(chg_pass), 32'h0);

    // Partial new code aborts; CHG in S_NEW ignored
    code4(16'h4321);
    chg();
    digit(4'h5);
    chg();
    check("newchg_phase", 32'(phase_new), 32'h1);
    check("newchg_cnt",   32'(digit_cnt), 32'd1);
    ent();
    check("abort_chg",     32'(chg_pass), 32'h0);
    check("abort_enter",   32'(enter), 32'h0);
    check("abort_phase",   32'(phase_new), 32'h0);
    check("abort_newpass", 32'(newpass), 32'h5678);
    check("abort_passin",  32'(passin), 32'habcd);

    // Reset in S_NEW after two new digits
    code4(16'h1234);
    chg();
    digit(4'h5); digit(4'h6);
    #2 reset = 1'b0;
    #1;
    check("mrst_passin",  32'(passin), 32'h0);
    check("mrst_newpass", 32'(newpass), 32'h0);
    check("mrst_cnt",     32'(digit_cnt), 32'd0);
    check("mrst_phase",   32'(phase_new), 32'h0);
    check("mrst_enter",   32'(enter), 32'h0);
    check("mrst_chg",     32'(chg_pass), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    code4(16'h1234);
    ent();
    check("post_enter",   32'(enter), 32'h1);
    check("post_chg",     32'(chg_pass), 32'h0);
    check("post_passin",  32'(passin), 32'h1234);
    check("post_newpass", 32'(newpass), 32'h0);

`ifdef KEYPAD_TIMEOUT_EN
    // Key 7, then idle until the timeout fires after 8 edges
    digit(4'h7);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check("to_early", 32'(timeout_evt), 32'h0);
    end
    @(negedge clk);
    check("to_evt", 32'(timeout_evt), 32'h1);
    check("to_cnt", 32'(digit_cnt), 32'd0);
    @(negedge clk);
    check("to_evt_1cyc", 32'(timeout_evt), 32'h0);

    // Key on the expiry cycle suppresses the timeout
    digit(4'h7);
    repeat (6) @(negedge clk);
    digit(4'h8);
    check("to_keywin_evt", 32'(timeout_evt), 32'h0);
    check("to_keywin_cnt", 32'(digit_cnt), 32'd2);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check("to_reload_early", 32'(timeout_evt), 32'h0);
    end
    @(negedge clk);
    check("to_reload_evt", 32'(timeout_evt), 32'h1);
    check("to_reload_cnt", 32'(digit_cnt), 32'd0);

    // Timeout in S_NEW with an empty buffer returns to S_OLD
    code4(16'h1111);
    chg();
    repeat (7) @(negedge clk);
    check("to_new_phase_pre", 32'(phase_new), 32'h1);
    @(negedge clk);
    check("to_new_evt",   32'(timeout_evt), 32'h1);
    check("to_new_phase", 32'(phase_new), 32'h0);
`else
    // Without the timeout a partial entry persists
    digit(4'h7);
    repeat (20) @(negedge clk);
    check("noto_evt", 32'(timeout_evt), 32'h0);
    check("noto_cnt", 32'(digit_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
